// File: rtl/alu_collect_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_collect_pkg
//  Description : Shared types and constants for the ALU result collector.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_collect_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SEL_W       = 4;
    localparam int DEF_SWEEP_CNT_W = 8;

    // One sweep covers every op code exactly once.
    localparam int OP_COUNT = 16;
    // Last op of a sweep (A<<1); it arrives with sel_in already wrapped to 0.
    localparam int OP_SHL   = 15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage : alu_collect_pkg
`default_nettype wire

// File: rtl/alu_result_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_collector_if
//  Description : Bundle of ALU-facing, control and read-port signals of the
//                collector. min_val/max_val exist only when
//                ALU_COLLECT_MINMAX_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_result_collector_if
    import alu_collect_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int SWEEP_CNT_W = DEF_SWEEP_CNT_W
) ();

    logic                   start;
    logic [DATA_W-1:0]      result_in;
    logic [SEL_W-1:0]       sel_in;
    logic [SEL_W-1:0]       rd_addr;
    logic [DATA_W-1:0]      rd_data;
    logic                   busy;
    logic                   sweep_done;
    logic                   seq_err;
    logic [DATA_W-1:0]      checksum;
    logic [SWEEP_CNT_W-1:0] sweep_count;
`ifdef ALU_COLLECT_MINMAX_EN
    logic [DATA_W-1:0]      min_val;
    logic [DATA_W-1:0]      max_val;

    modport master (
        output start, result_in, sel_in, rd_addr,
        input  rd_data, busy, sweep_done, seq_err, checksum, sweep_count,
        input  min_val, max_val
    );
    modport slave (
        input  start, result_in, sel_in, rd_addr,
        output rd_data, busy, sweep_done, seq_err, checksum, sweep_count,
        output min_val, max_val
    );
`else
    modport master (
        output start, result_in, sel_in, rd_addr,
        input  rd_data, busy, sweep_done, seq_err, checksum, sweep_count
    );
    modport slave (
        input  start, result_in, sel_in, rd_addr,
        output rd_data, busy, sweep_done, seq_err, checksum, sweep_count
    );
`endif

endinterface : alu_result_collector_if
`default_nettype wire

// File: rtl/alu_result_bank.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_bank
//  Description : OP_COUNT x DATA_W register bank, synchronous write,
//                registered read (read-before-write on collision),
//                synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_bank
    import alu_collect_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              wr_en,
    input  wire logic [SEL_W-1:0]  wr_addr,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic [SEL_W-1:0]  rd_addr,
    output logic      [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [OP_COUNT];

    // Storage plus read register; the read samples mem before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < OP_COUNT; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            rd_data <= mem[rd_addr];
        end
    end

endmodule : alu_result_bank
`default_nettype wire

// File: rtl/alu_result_collector.sv
`default_nettype none
// ============================================================================
//  Module      : alu_result_collector
//  Description : Captures one 16-op sweep of the self-sequencing ALU into a
//                result bank, with XOR checksum, saturating sweep counter
//                and sequencing-error detection.
//                Optional feature macro: ALU_COLLECT_MINMAX_EN (min/max).
//  Revision    : 1.0  initial release
// ============================================================================
module alu_result_collector
    import alu_collect_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SEL_W       = DEF_SEL_W,
    parameter int SWEEP_CNT_W = DEF_SWEEP_CNT_W
) (
    input wire logic              clk,
    input wire logic              rst,
    alu_result_collector_if.slave bus
);

    state_t                 state;
    state_t                 next_state;
    logic [SEL_W-1:0]       exp_sel;
    logic [DATA_W-1:0]      checksum;
    logic [SWEEP_CNT_W-1:0] sweep_count;
    logic                   seq_err;
    logic [DATA_W-1:0]      rd_data;

    // sel_in points one past the op that produced result_in.
    logic [SEL_W-1:0] wr_addr;
    logic             sel_is_one;
    logic             sel_match;
    logic             arm_hit;
    logic             cap_hit;
    logic             cap_last;

    assign wr_addr    = bus.sel_in - SEL_W'(1);
    assign sel_is_one = (bus.sel_in == SEL_W'(1));
    assign sel_match  = (bus.sel_in == exp_sel);
    assign arm_hit    = (state == ARMED) && sel_is_one;
    assign cap_hit    = (state == CAPTURE) && sel_match;
    assign cap_last   = cap_hit && (wr_addr == SEL_W'(OP_SHL));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = ARMED;
            ARMED:   if (sel_is_one) next_state = CAPTURE;
            CAPTURE: begin
                if (!sel_match) begin
                    next_state = IDLE;
                end else if (cap_last) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = bus.start ? ARMED : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Moore status outputs.
    always_comb begin
        bus.busy       = (state == ARMED) || (state == CAPTURE);
        bus.sweep_done = (state == DONE);
    end

    // Checksum, expected-sel tracker, sweep counter and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_sel     <= '0;
            checksum    <= '0;
            sweep_count <= '0;
            seq_err     <= 1'b0;
        end else begin
            seq_err <= (state == CAPTURE) && !sel_match;
            if (arm_hit) begin
                checksum <= bus.result_in;
                exp_sel  <= SEL_W'(2);
            end else if (cap_hit) begin
                checksum <= checksum ^ bus.result_in;
                exp_sel  <= exp_sel + SEL_W'(1);
            end
            // Counter moves on entry to DONE so it is current alongside sweep_done.
            if (cap_last && (sweep_count != '1)) begin
                sweep_count <= sweep_count + SWEEP_CNT_W'(1);
            end
        end
    end

`ifdef ALU_COLLECT_MINMAX_EN
    logic [DATA_W-1:0] min_val;
    logic [DATA_W-1:0] max_val;

    // Running unsigned extremes of the current sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_val <= '0;
            max_val <= '0;
        end else if (arm_hit) begin
            min_val <= bus.result_in;
            max_val <= bus.result_in;
        end else if (cap_hit) begin
            if (bus.result_in < min_val) min_val <= bus.result_in;
            if (bus.result_in > max_val) max_val <= bus.result_in;
        end
    end

    assign bus.min_val = min_val;
    assign bus.max_val = max_val;
`endif

    alu_result_bank #(
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (arm_hit || cap_hit),
        .wr_addr (wr_addr),
        .wr_data (bus.result_in),
        .rd_addr (bus.rd_addr),
        .rd_data (rd_data)
    );

    assign bus.rd_data     = rd_data;
    assign bus.checksum    = checksum;
    assign bus.sweep_count = sweep_count;
    assign bus.seq_err     = seq_err;

endmodule : alu_result_collector
`default_nettype wire
